// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM front end: command-op encodings between the
// arbiter and the command sequencer, arbiter state encodings, the default
// refresh interval, refresh-debt limits and the raw SDRAM command pin codes
// used by the sequencer.
// Configuration macro: SDRAM_REFRESH_POSTPONE_EN (deep refresh debt of 8).
// -----------------------------------------------------------------------------
package sdram_pkg;

  typedef enum logic [1:0] {
    CMD_OP_NONE    = 2'b00,
    CMD_OP_READ    = 2'b01,
    CMD_OP_WRITE   = 2'b10,
    CMD_OP_REFRESH = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_BUSY  = 2'b10
  } arb_state_e;

  // 7.8 us at 100 MHz: 8192 rows every 64 ms
  localparam int unsigned REFRESH_INTERVAL_DEFAULT = 780;

`ifdef SDRAM_REFRESH_POSTPONE_EN
  // JEDEC allows up to 8 postponed auto-refreshes
  localparam logic [3:0] REFRESH_DEBT_MAX = 4'd8;
`else
  localparam logic [3:0] REFRESH_DEBT_MAX = 4'd1;
`endif

  // SDRAM command pins {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] SDRAM_CMD_MRS       = 4'b0000;
  localparam logic [3:0] SDRAM_CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] SDRAM_CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] SDRAM_CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] SDRAM_CMD_WRITE     = 4'b0100;
  localparam logic [3:0] SDRAM_CMD_READ      = 4'b0101;
  localparam logic [3:0] SDRAM_CMD_NOP       = 4'b0111;

  // Saturating increment of the refresh debt
  function automatic logic [3:0] debt_sat_inc(input logic [3:0] debt);
    logic [3:0] res;
    if (debt >= REFRESH_DEBT_MAX) begin
      res = REFRESH_DEBT_MAX;
    end else begin
      res = debt + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// -----------------------------------------------------------------------------
// sdram_refresh_timer
// Periodic auto-refresh tick generator plus refresh-debt accumulator.
//   clk, reset_n     : clock, asynchronous active-low reset
//   init_done        : timer is held at its reload value until 1
//   refresh_grant    : arbiter granted a refresh this cycle (debt - 1)
//   debt             : outstanding refreshes (saturates at REFRESH_DEBT_MAX)
//   refresh_pending  : registered (debt != 0)
// Configuration macro: SDRAM_REFRESH_POSTPONE_EN (via sdram_pkg debt limit).
// -----------------------------------------------------------------------------
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_done,
  input  logic       refresh_grant,
  output logic [3:0] debt,
  output logic       refresh_pending
);

  localparam int unsigned   TW     = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [TW-1:0] ONE    = TW'(1);
  localparam logic [TW-1:0] ZERO   = TW'(0);

  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    debt_q, debt_d;
  logic          pending_q;
  logic          tick_s;

  // Down-counter and debt next-state
  always_comb begin
    tick_s  = 1'b0;
    timer_d = timer_q;
    debt_d  = debt_q;
    if (!init_done) begin
      timer_d = RELOAD;
    end else if (timer_q == ZERO) begin
      timer_d = RELOAD;
      tick_s  = 1'b1;
    end else begin
      timer_d = timer_q - ONE;
    end
    // tick and grant together cancel out
    case ({tick_s, refresh_grant})
      2'b10:   debt_d = debt_sat_inc(debt_q);
      2'b01:   debt_d = debt_q - 4'd1;
      default: debt_d = debt_q;
    endcase
  end

  // Timer, debt and pending flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= RELOAD;
      debt_q    <= 4'd0;
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      debt_q    <= debt_d;
      pending_q <= (debt_d != 4'd0);
    end
  end

  assign debt            = debt_q;
  assign refresh_pending = pending_q;

endmodule

// File: rtl/sdram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_req_arbiter
// Shares one SDRAM command sequencer between a read requester, a write
// requester and the periodic auto-refresh. One operation in flight at a time:
// IDLE (grant) -> ISSUE (cmd_valid until cmd_ready) -> BUSY (until cmd_done).
//   clk, reset_n                 : clock, asynchronous active-low reset
//   init_done                    : SDRAM init complete; no grants before it
//   rd_req_valid/ready/addr/len  : read request channel (ready is a 1-cycle
//                                  accept strobe, combinational in IDLE)
//   wr_req_valid/ready/addr/len  : write request channel
//   cmd_valid/ready/op/addr/len  : command to sequencer (registered)
//   cmd_done                     : sequencer finished (honoured in BUSY only)
//   refresh_pending              : refresh debt non-zero
// Configuration macro: SDRAM_REFRESH_POSTPONE_EN -- refresh is deferred while
// rd/wr traffic is waiting until 8 refreshes are owed.
// -----------------------------------------------------------------------------
module sdram_req_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
  parameter bit          IS_READ_PRIORITY = 1'b1,
  parameter int unsigned STARVE_LIMIT     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_done,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [7:0]            rd_req_len,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [7:0]            wr_req_len,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [1:0]            cmd_op,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  input  logic                  cmd_done,
  output logic                  refresh_pending
);

  localparam int unsigned   SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_ZERO = SW'(0);

  arb_state_e            state_q, state_d;
  cmd_op_e               cmd_op_q, cmd_op_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]            cmd_len_q, cmd_len_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  prefer_wr_q, prefer_wr_d;
  logic                  arb_en_q;

  logic [3:0]            debt_s;
  logic                  refresh_ok_s;
  logic                  grant_ref_s, grant_rd_s, grant_wr_s;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh (
    .clk             (clk),
    .reset_n         (reset_n),
    .init_done       (init_done),
    .refresh_grant   (grant_ref_s),
    .debt            (debt_s),
    .refresh_pending (refresh_pending)
  );

  // Refresh eligibility
  always_comb begin
`ifdef SDRAM_REFRESH_POSTPONE_EN
    refresh_ok_s = (debt_s != 4'd0) &&
                   (!(rd_req_valid || wr_req_valid) || (debt_s >= REFRESH_DEBT_MAX));
`else
    refresh_ok_s = (debt_s != 4'd0);
`endif
  end

  // Grant selection; arb_en_q keeps readies low while reset is asserted
  always_comb begin
    grant_ref_s = 1'b0;
    grant_rd_s  = 1'b0;
    grant_wr_s  = 1'b0;
    if ((state_q == ARB_IDLE) && arb_en_q && init_done) begin
      if (refresh_ok_s) begin
        grant_ref_s = 1'b1;
      end else if (rd_req_valid && wr_req_valid) begin
        if (IS_READ_PRIORITY) begin
          if (starve_q >= STARVE_MAX) begin
            grant_wr_s = 1'b1;
          end else begin
            grant_rd_s = 1'b1;
          end
        end else begin
          if (prefer_wr_q) begin
            grant_wr_s = 1'b1;
          end else begin
            grant_rd_s = 1'b1;
          end
        end
      end else if (rd_req_valid) begin
        grant_rd_s = 1'b1;
      end else if (wr_req_valid) begin
        grant_wr_s = 1'b1;
      end else begin
        grant_ref_s = 1'b0;
      end
    end else begin
      grant_ref_s = 1'b0;
    end
  end

  // Starvation counter (read-priority) and alternation pointer next-state
  always_comb begin
    starve_d    = starve_q;
    prefer_wr_d = prefer_wr_q;
    if (grant_wr_s) begin
      starve_d    = STARVE_ZERO;
      prefer_wr_d = 1'b0;
    end else if (grant_rd_s) begin
      prefer_wr_d = 1'b1;
      // only reads granted over a waiting write count toward starvation
      if (!wr_req_valid) begin
        starve_d = STARVE_ZERO;
      end else if (starve_q < STARVE_MAX) begin
        starve_d = starve_q + STARVE_ONE;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Command FSM next-state and command register next values
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_ref_s) begin
          state_d     = ARB_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = CMD_OP_REFRESH;
          cmd_addr_d  = {ADDR_WIDTH{1'b0}};
          cmd_len_d   = 8'd0;
        end else if (grant_rd_s) begin
          state_d     = ARB_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = CMD_OP_READ;
          cmd_addr_d  = rd_req_addr;
          cmd_len_d   = rd_req_len;
        end else if (grant_wr_s) begin
          state_d     = ARB_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = CMD_OP_WRITE;
          cmd_addr_d  = wr_req_addr;
          cmd_len_d   = wr_req_len;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ARB_BUSY;
          cmd_valid_d = 1'b0;
        end else begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_BUSY: begin
        if (cmd_done) begin
          state_d  = ARB_IDLE;
          cmd_op_d = CMD_OP_NONE;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        cmd_valid_d = 1'b0;
        cmd_op_d    = CMD_OP_NONE;
      end
    endcase
  end

  // State and command registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= CMD_OP_NONE;
      cmd_addr_q  <= {ADDR_WIDTH{1'b0}};
      cmd_len_q   <= 8'd0;
      starve_q    <= STARVE_ZERO;
      prefer_wr_q <= 1'b0;
      arb_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      starve_q    <= starve_d;
      prefer_wr_q <= prefer_wr_d;
      arb_en_q    <= 1'b1;
    end
  end

  assign rd_req_ready = grant_rd_s;
  assign wr_req_ready = grant_wr_s;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_op       = cmd_op_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_len      = cmd_len_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench: two arbiters (read-priority and alternating) share stimulus.
module tb_sdram_req_arbiter;

  localparam int RI = 780;
  localparam logic [31:0] A_RD = 32'h0000_1000;
  localparam logic [31:0] A_WR = 32'h0000_2000;
  localparam logic [31:0] A_Z  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n, init_done, rd_v, wr_v, cmd_ready, cmd_done;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  rd_len, wr_len;

  logic        a_rd_rdy, a_wr_rdy, a_cmd_valid, a_pend;
  logic [1:0]  a_cmd_op;
  logic [31:0] a_cmd_addr;
  logic [7:0]  a_cmd_len;
  logic        b_rd_rdy, b_wr_rdy, b_cmd_valid, b_pend;
  logic [1:0]  b_cmd_op;
  logic [31:0] b_cmd_addr;
  logic [7:0]  b_cmd_len;

  logic [37:0] obs_a, obs_b;
  assign obs_a = {a_rd_rdy, a_wr_rdy, a_cmd_valid, a_cmd_op, a_pend, a_cmd_addr};
  assign obs_b = {b_rd_rdy, b_wr_rdy, b_cmd_valid, b_cmd_op, b_pend, b_cmd_addr};

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_req_arbiter #(
    .ADDR_WIDTH(32), .REFRESH_INTERVAL(RI), .IS_READ_PRIORITY(1'b1), .STARVE_LIMIT(4)
  ) dut_rp (
    .clk(clk), .reset_n(reset_n), .init_done(init_done),
    .rd_req_valid(rd_v), .rd_req_ready(a_rd_rdy), .rd_req_addr(rd_addr), .rd_req_len(rd_len),
    .wr_req_valid(wr_v), .wr_req_ready(a_wr_rdy), .wr_req_addr(wr_addr), .wr_req_len(wr_len),
    .cmd_valid(a_cmd_valid), .cmd_ready(cmd_ready), .cmd_op(a_cmd_op), .cmd_addr(a_cmd_addr),
    .cmd_len(a_cmd_len), .cmd_done(cmd_done), .refresh_pending(a_pend)
  );

  sdram_req_arbiter #(
    .ADDR_WIDTH(32), .REFRESH_INTERVAL(RI), .IS_READ_PRIORITY(1'b0), .STARVE_LIMIT(4)
  ) dut_alt (
    .clk(clk), .reset_n(reset_n), .init_done(init_done),
    .rd_req_valid(rd_v), .rd_req_ready(b_rd_rdy), .rd_req_addr(rd_addr), .rd_req_len(rd_len),
    .wr_req_valid(wr_v), .wr_req_ready(b_wr_rdy), .wr_req_addr(wr_addr), .wr_req_len(wr_len),
    .cmd_valid(b_cmd_valid), .cmd_ready(cmd_ready), .cmd_op(b_cmd_op), .cmd_addr(b_cmd_addr),
    .cmd_len(b_cmd_len), .cmd_done(cmd_done), .refresh_pending(b_pend)
  );

  typedef struct packed {
    logic        init;
    logic        rd;
    logic        wr;
    logic        rdy;
    logic        dn;
    logic        e_rr;
    logic        e_wr;
    logic        e_v;
    logic [1:0]  e_op;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [37:0] mk_obs(input logic rr, input logic wr, input logic v,
                                         input logic [1:0] op, input logic pend,
                                         input logic [31:0] addr);
    return {rr, wr, v, op, pend, addr};
  endfunction

  task automatic chk_obs(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {rr,wr,v,op,pend,addr}=0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    bit [9:0] exp_w_a;
    bit [9:0] exp_w_b;
    int na, nb, prev_a, prev_b;

    //              init rd wr rdy dn  rr wr v  op     addr
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 2'b00, A_Z};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 2'b01, A_RD};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1, 2'b01, A_RD};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 2'b01, A_RD};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 2'b01, A_RD};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 2'b00, A_RD};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1, 2'b10, A_WR};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1, 2'b10, A_WR};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 2'b10, A_WR};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 2'b10, A_WR};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 2'b00, A_WR};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 2'b00, A_WR};
    tbl[12] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 2'b00, A_WR};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1, 2'b10, A_WR};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 2'b10, A_WR};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 2'b00, A_WR};

    exp_w_a = 10'b10_0001_0000;  // R R R R W R R R R W (bit i = grant i is write)
    exp_w_b = 10'b10_1010_1010;  // R W R W ...

    reset_n = 1'b0; init_done = 1'b1; rd_v = 1'b1; wr_v = 1'b0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    rd_addr = A_RD; wr_addr = A_WR; rd_len = 8'h5a; wr_len = 8'h07;

    // Reset state, even with a read pending
    #12;
    chk_obs("reset_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, A_Z));
    chk_obs("reset_alt", obs_b, mk_obs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, A_Z));

    // First refresh: cmd_valid appears after edge 781 following release
    @(negedge clk);
    rd_v = 1'b0;
    reset_n = 1'b1;
    for (int i = 1; i <= RI; i++) @(posedge clk);
    #1;
    chk_obs("ref_edge780_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, A_Z));
    @(posedge clk); #1;
    chk_obs("ref_edge781_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, A_Z));
    chk_obs("ref_edge781_alt", obs_b, mk_obs(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, A_Z));
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    chk_obs("ref_busy_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, A_Z));
    cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    chk_obs("ref_done_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, A_Z));

    // Per-cycle handshake vectors
    for (int i = 0; i < 16; i++) begin
      init_done = tbl[i].init; rd_v = tbl[i].rd; wr_v = tbl[i].wr;
      cmd_ready = tbl[i].rdy;  cmd_done = tbl[i].dn;
      @(negedge clk);
      chk_obs($sformatf("vec%0d_rp", i), obs_a,
              mk_obs(tbl[i].e_rr, tbl[i].e_wr, tbl[i].e_v, tbl[i].e_op, 1'b0, tbl[i].e_addr));
      chk_obs($sformatf("vec%0d_alt", i), obs_b,
              mk_obs(tbl[i].e_rr, tbl[i].e_wr, tbl[i].e_v, tbl[i].e_op, 1'b0, tbl[i].e_addr));
      @(posedge clk); #1;
    end

    // Both requesters always valid, sequencer acks immediately
    rd_v = 1'b1; wr_v = 1'b1; cmd_ready = 1'b1; cmd_done = 1'b1;
    na = 0; nb = 0; prev_a = 0; prev_b = 0;
    for (int cyc = 0; cyc < 60 && (na < 10 || nb < 10); cyc++) begin
      @(negedge clk);
      if (prev_a != 0) chk_int("addr_after_grant_rp", int'(a_cmd_addr), (prev_a == 1) ? int'(A_RD) : int'(A_WR));
      if (prev_b != 0) chk_int("addr_after_grant_alt", int'(b_cmd_addr), (prev_b == 1) ? int'(A_RD) : int'(A_WR));
      prev_a = 0; prev_b = 0;
      if ((a_rd_rdy || a_wr_rdy) && na < 10) begin
        chk_int($sformatf("grant%0d_rp", na), int'({a_rd_rdy, a_wr_rdy}), exp_w_a[na] ? 1 : 2);
        prev_a = a_rd_rdy ? 1 : 2;
        na++;
      end
      if ((b_rd_rdy || b_wr_rdy) && nb < 10) begin
        chk_int($sformatf("grant%0d_alt", nb), int'({b_rd_rdy, b_wr_rdy}), exp_w_b[nb] ? 1 : 2);
        prev_b = b_rd_rdy ? 1 : 2;
        nb++;
      end
    end
    chk_int("grant_count_rp", na, 10);
    chk_int("grant_count_alt", nb, 10);
    @(posedge clk); #1;
    rd_v = 1'b0; wr_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmd_ready = 1'b0; cmd_done = 1'b0;

    // Stall in ISSUE for 10 cycles with both requesters still valid
    rd_v = 1'b1; wr_v = 1'b1;
    @(negedge clk);
    chk_int("stall_grant_rp", int'({a_rd_rdy, a_wr_rdy}), 2);
    chk_int("stall_grant_alt", int'({b_rd_rdy, b_wr_rdy}), 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_obs($sformatf("stall%0d_rp", i), obs_a, mk_obs(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, A_RD));
      chk_obs($sformatf("stall%0d_alt", i), obs_b, mk_obs(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, A_RD));
      chk_int($sformatf("stall%0d_len", i), int'(a_cmd_len), 32'h5a);
    end
    cmd_ready = 1'b1; rd_v = 1'b0; wr_v = 1'b0;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    chk_obs("busy_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, A_RD));

    // Asynchronous reset while BUSY
    #2;
    reset_n = 1'b0; rd_v = 1'b1;
    #1;
    chk_obs("async_reset_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, A_Z));
    chk_obs("async_reset_alt", obs_b, mk_obs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, A_Z));
    chk_int("async_reset_len", int'(a_cmd_len), 0);
    @(negedge clk);
    rd_v = 1'b0; reset_n = 1'b1; cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    chk_obs("stray_done_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, A_Z));
    wr_v = 1'b1;
    @(negedge clk);
    chk_int("resume_grant_rp", int'({a_rd_rdy, a_wr_rdy}), 1);
    chk_int("resume_grant_alt", int'({b_rd_rdy, b_wr_rdy}), 1);
    @(posedge clk); #1;
    wr_v = 1'b0;
    chk_obs("resume_cmd_rp", obs_a, mk_obs(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, A_WR));
    chk_int("resume_len_rp", int'(a_cmd_len), 7);

`ifdef SDRAM_REFRESH_POSTPONE_EN
    begin
      int nref, first_ref;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; rd_v = 1'b1; cmd_ready = 1'b1; cmd_done = 1'b1;
      nref = 0; first_ref = 0;
      for (int cyc = 1; cyc <= 9 * RI + 20; cyc++) begin
        @(posedge clk); #1;
        if (a_cmd_valid && a_cmd_op == 2'b11) begin
          if (nref == 0) first_ref = cyc;
          nref++;
        end
      end
      chk_int("postpone_ref_count", nref, 2);
      chk_int("postpone_first_ok", int'(first_ref >= 8 * RI), 1);
      rd_v = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Front-end scheduler for the SDRAM command sequencer (ACT/READ/WRITE/PRE engine).
- Shares the single SDRAM resource between a read requester (AXI AR side), a write requester (AXI AW/W side) and an internal periodic auto-refresh timer.
- Issues one operation at a time to the sequencer over a valid/ready handshake, then waits for completion before the next grant.

Parameters:
- ADDR_WIDTH, 32, request/command address width
- REFRESH_INTERVAL, 780, clk cycles between refresh ticks (7.8 us at 100 MHz; 8192 rows / 64 ms)
- IS_READ_PRIORITY, 1, 1 = read preferred with starvation guard; 0 = strict read/write alternation
- STARVE_LIMIT, 4, consecutive preferred grants allowed while the other side waits

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- init_done  in  1  SDRAM power-up/MRS sequence complete
- rd_req_valid  in  1  read request pending
- rd_req_ready  out  1  read request accepted this cycle
- rd_req_addr  in  ADDR_WIDTH  read byte address
- rd_req_len  in  8  AXI-style beats minus 1
- wr_req_valid  in  1  write request pending
- wr_req_ready  out  1  write request accepted this cycle
- wr_req_addr  in  ADDR_WIDTH  write byte address
- wr_req_len  in  8  beats minus 1
- cmd_valid  out  1  command offered to sequencer
- cmd_ready  in  1  sequencer accepts command
- cmd_op  out  2  01 read, 10 write, 11 refresh, 00 none
- cmd_addr  out  ADDR_WIDTH  captured address (0 for refresh)
- cmd_len  out  8  captured length (0 for refresh)
- cmd_done  in  1  single-cycle pulse: sequencer finished the operation
- refresh_pending  out  1  refresh debt > 0

Behaviour:
- Reset: state IDLE. All outputs 0: cmd_valid, cmd_op, cmd_addr, cmd_len, rd/wr_req_ready, refresh_pending. Refresh debt 0, refresh timer loaded with REFRESH_INTERVAL-1, starvation counter 0, alternation pointer = read.
- Reset asserted mid-operation returns to these values immediately, with no drain.
- While init_done=0:
  - no grants; readies held 0;
  - timer held at reload value.
- Refresh timer:
  - down-counts each cycle;
  - at 0 it reloads and emits a tick;
  - a tick increments debt, saturating at the maximum.
  - If a tick and a refresh grant occur in the same cycle, debt is unchanged.
- State machine IDLE -> ISSUE -> BUSY -> IDLE:
  - IDLE, grant selection in priority order:
    1. refresh (per debt rule);
    2. rd/wr per priority rule.
  - IDLE, on a rd/wr grant: the matching *_req_ready is high for exactly that cycle (combinational from state, grant and valid), and addr/len are registered into cmd_addr/cmd_len.
  - IDLE, on a refresh grant: debt decrements.
  - IDLE -> ISSUE: cmd_valid=1 from the next cycle (grant-to-cmd_valid latency 1).
  - ISSUE: cmd_valid, cmd_op, cmd_addr and cmd_len are held stable until cmd_ready=1. On the cmd_ready cycle, move to BUSY and drop cmd_valid on the next cycle.
  - BUSY: wait for cmd_done, then go to IDLE; cmd_op returns to 00.
  - A cmd_done outside BUSY is ignored.
  - Minimum request-to-request spacing: 3 cycles plus sequencer time.
- Priority, IS_READ_PRIORITY=1:
  - read wins when both are valid.
  - A counter tracks consecutive read grants while wr_req_valid=1. When it reaches STARVE_LIMIT, the next grant goes to write and the counter clears.
  - The counter also clears on any write grant.
- Priority, IS_READ_PRIORITY=0:
  - when both are valid, the side opposite the last grant wins;
  - when only one is valid, it wins;
  - the pointer updates on every rd/wr grant.
- Refresh rule, base build:
  - debt saturates at 1;
  - any debt preempts rd/wr at the next IDLE;
  - refresh_pending = (debt != 0).
- No request is ever dropped. A valid request is held by the requester until ready; the arbiter never asserts ready without capturing.

Optional Feature:
- Macro: SDRAM_REFRESH_POSTPONE_EN.
- Defined:
  - 4-bit debt, saturating at 8;
  - refresh is granted in IDLE only when no rd/wr is valid, or when debt >= 8 (forced);
  - the JEDEC 8-refresh postponement lets read bursts proceed uninterrupted.
- Undefined: base rule (debt max 1, immediate preemption).

Decomposition:
- Shared package sdram_pkg:
  - cmd_op encodings (CMD_OP_NONE/READ/WRITE/REFRESH);
  - arbiter state encodings;
  - default REFRESH_INTERVAL;
  - SDRAM command localparams reused by the sequencer.
- One natural sub-module, sdram_refresh_timer: down-counter plus debt accumulator, with tick/grant in and debt/pending out.

Test Plan:
- Reset with init_done=1, no requests, REFRESH_INTERVAL=780 -> first cmd_valid with cmd_op=11 on cycle 781 after reset_n rises; after cmd_ready then cmd_done, refresh_pending=0.
- rd_req_valid and wr_req_valid both held high, IS_READ_PRIORITY=1, STARVE_LIMIT=4, sequencer acks immediately -> grant order R,R,R,R,W,R,R,R,R,W.
- IS_READ_PRIORITY=0, both valid continuously -> grants strictly alternate R,W,R,W; rd_req_addr=0x1000 appears on cmd_addr one cycle after rd_req_ready.
- cmd_ready held low 10 cycles in ISSUE -> cmd_valid/op/addr/len stable all 10 cycles; no second ready pulse to either requester.
- SDRAM_REFRESH_POSTPONE_EN, reads continuously valid for 9 x REFRESH_INTERVAL -> refresh forced only when debt reaches 8; debt never exceeds 8.
- reset_n pulsed low while in BUSY -> all outputs 0 asynchronously, debt 0; a later cmd_done is ignored; normal arbitration resumes.
